// File: rtl/ibex_obi_mem_pkg.sv
// ---------------------------------------------------------------------------
// ibex_obi_mem_pkg
//
// Shared definitions for the Ibex bus memory responder:
//   obi_rsp_t                  - one response beat {err, rdata, rdata_intg}
//   MaxLatency                 - deepest supported response pipeline
//   RspIdle                    - response value carried by idle pipeline slots
//   prim_secded_inv_39_32_enc  - inverted SECDED(39,32) encoder
//   intg_enc                   - 7 integrity bits of a 32-bit word
//   sat_inc                    - saturating 32-bit increment
// ---------------------------------------------------------------------------
package ibex_obi_mem_pkg;

  localparam int unsigned MaxLatency = 32'd8;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
  } obi_rsp_t;

  // Inverted Hsiao SECDED(39,32). Inversion of check bits 1/3/5 makes an
  // all-zero codeword (e.g. a stuck bus) decode as an error.
  function automatic logic [38:0] prim_secded_inv_39_32_enc(input logic [31:0] data_i);
    logic [38:0] data_o;
    data_o     = {7'b000_0000, data_i};
    data_o[32] = ^(data_o & 39'h00_2606_BD25);
    data_o[33] = ^(data_o & 39'h00_DEBA_8050);
    data_o[34] = ^(data_o & 39'h00_413D_89AA);
    data_o[35] = ^(data_o & 39'h00_3123_4ED1);
    data_o[36] = ^(data_o & 39'h00_C2C1_323B);
    data_o[37] = ^(data_o & 39'h00_2DCC_624C);
    data_o[38] = ^(data_o & 39'h00_9850_5586);
    data_o     = data_o ^ 39'h2A_0000_0000;
    return data_o;
  endfunction

  function automatic logic [6:0] intg_enc(input logic [31:0] data);
    logic [38:0] cw;
    cw = prim_secded_inv_39_32_enc(data);
    return cw[38:32];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    logic [31:0] res;
    if (en && (cnt != 32'hFFFF_FFFF)) begin
      res = cnt + 32'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Idle slots still carry a valid codeword so rdata_intg always matches rdata.
  localparam obi_rsp_t RspIdle = '{err: 1'b0, rdata: 32'h0000_0000, rdata_intg: intg_enc(32'h0000_0000)};

endpackage

// File: rtl/ibex_obi_rsp_pipe.sv
// ---------------------------------------------------------------------------
// ibex_obi_rsp_pipe
//
// Fixed-depth, never-stalling shift register of {valid, obi_rsp_t}. An entry
// written in cycle N appears on the outputs in cycle N+Depth. Outputs come
// straight from the last stage flops.
//
// Ports:
//   clk_i, rst_ni  - clock, synchronous active-low reset (drops all entries)
//   in_valid_i     - a response enters the pipeline this cycle
//   in_rsp_i       - payload of that response
//   out_valid_o    - response retiring this cycle
//   out_rsp_o      - payload of the retiring response
// ---------------------------------------------------------------------------
module ibex_obi_rsp_pipe
  import ibex_obi_mem_pkg::*;
#(
  parameter int unsigned Depth = 32'd1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     in_valid_i,
  input  obi_rsp_t in_rsp_i,
  output logic     out_valid_o,
  output obi_rsp_t out_rsp_o
);

  localparam int unsigned RspW  = $bits(obi_rsp_t);
  localparam int unsigned PipeW = Depth * RspW;

  // Stage 0 lives in the low bits; a shift moves every entry one stage on.
  logic [Depth-1:0] valid_d, valid_q;
  logic [PipeW-1:0] rsp_d, rsp_q;

  // Next-state of the shift register: shift up by one stage, insert at stage 0.
  always_comb begin
    valid_d = (valid_q << 1) | Depth'(in_valid_i);
    rsp_d   = (rsp_q << RspW) | PipeW'(in_rsp_i);
  end

  // Stage flops; reset empties the pipeline and parks idle payloads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= {Depth{1'b0}};
      rsp_q   <= {Depth{RspIdle}};
    end else begin
      valid_q <= valid_d;
      rsp_q   <= rsp_d;
    end
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_rsp_o   = obi_rsp_t'(rsp_q[PipeW-1 -: RspW]);

endmodule

// File: rtl/ibex_obi_mem_responder.sv
// ---------------------------------------------------------------------------
// ibex_obi_mem_responder
//
// Memory-side responder for one Ibex req/gnt/rvalid bus port. Word reads and
// byte-enabled writes hit an internal array in the grant cycle; responses
// come back in order exactly Latency cycles after the grant.
//
// Ports:
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   req_i / gnt_o          - request handshake (gnt_o is combinational)
//   we_i, be_i, addr_i     - write flag, byte enables, byte address
//   wdata_i, wdata_intg_i  - write data and its 7 integrity bits
//   gnt_stall_i            - back-pressure, holds gnt_o low
//   rvalid_o, rdata_o,
//   rdata_intg_o, err_o    - registered response beat
//   intg_err_o             - grant of a write carrying bad integrity
//   rd_cnt_o, wr_cnt_o,
//   err_cnt_o              - saturating event counters
// ---------------------------------------------------------------------------
module ibex_obi_mem_responder
  import ibex_obi_mem_pkg::*;
#(
  parameter int unsigned MemWords = 32'd4096,
  parameter logic [31:0] AddrBase = 32'h0010_0000,
  parameter int unsigned Latency  = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  input  logic        gnt_stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o,
  output logic        intg_err_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] err_cnt_o
);

  localparam int unsigned IdxW      = (MemWords > 32'd1) ? $clog2(MemWords) : 32'd1;
  localparam logic [31:0] MemBytes  = 32'(MemWords) << 2;
  // Out-of-range Latency values are clamped to the supported window.
  localparam int unsigned PipeDepth = (Latency < 32'd1)      ? 32'd1 :
                                      (Latency > MaxLatency) ? MaxLatency : Latency;

  logic [31:0] mem_q [MemWords];

  logic            handshake;
  logic [31:0]     addr_off;
  logic            addr_err;
  logic            intg_bad;
  logic            req_err;
  logic            mem_we;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     mem_rdata;
  obi_rsp_t        rsp_in;
  logic            rsp_valid;
  obi_rsp_t        rsp_out;

  logic [31:0] rd_cnt_d, rd_cnt_q;
  logic [31:0] wr_cnt_d, wr_cnt_q;
  logic [31:0] err_cnt_d, err_cnt_q;

  // Request decode: handshake, error classification and the grant-cycle read.
  always_comb begin
    gnt_o     = req_i & ~gnt_stall_i & rst_ni;
    handshake = req_i & gnt_o;
    addr_off  = addr_i - AddrBase;
    addr_err  = (addr_i < AddrBase) | (addr_off >= MemBytes) | (addr_i[1:0] != 2'b00);
    intg_bad  = we_i & (wdata_intg_i != intg_enc(wdata_i));
    // Address errors take priority, so a bad address never flags integrity.
    req_err    = addr_err | intg_bad;
    intg_err_o = handshake & ~addr_err & intg_bad;
    word_idx   = addr_off[IdxW+1:2];
    mem_we     = handshake & we_i & ~req_err;
    if (handshake && !we_i && !req_err) begin
      mem_rdata = mem_q[word_idx];
    end else begin
      mem_rdata = 32'h0000_0000;
    end
    rsp_in.err        = handshake & req_err;
    rsp_in.rdata      = mem_rdata;
    rsp_in.rdata_intg = intg_enc(mem_rdata);
    rsp_valid         = handshake;
  end

  // Counter next-state; every accepted request bumps exactly one counter.
  always_comb begin
    rd_cnt_d  = sat_inc(rd_cnt_q,  handshake & ~req_err & ~we_i);
    wr_cnt_d  = sat_inc(wr_cnt_q,  handshake & ~req_err &  we_i);
    err_cnt_d = sat_inc(err_cnt_q, handshake &  req_err);
  end

  // Byte-enabled array write; no reset so the array can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (be_i[0]) mem_q[word_idx][7:0]   <= wdata_i[7:0];
      if (be_i[1]) mem_q[word_idx][15:8]  <= wdata_i[15:8];
      if (be_i[2]) mem_q[word_idx][23:16] <= wdata_i[23:16];
      if (be_i[3]) mem_q[word_idx][31:24] <= wdata_i[31:24];
    end
  end

  // Event counter flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_q  <= 32'h0000_0000;
      wr_cnt_q  <= 32'h0000_0000;
      err_cnt_q <= 32'h0000_0000;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  ibex_obi_rsp_pipe #(
    .Depth (PipeDepth)
  ) u_rsp_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (rsp_valid),
    .in_rsp_i    (rsp_in),
    .out_valid_o (rvalid_o),
    .out_rsp_o   (rsp_out)
  );

  assign rdata_o      = rsp_out.rdata;
  assign rdata_intg_o = rsp_out.rdata_intg;
  assign err_o        = rsp_out.err;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_ibex_obi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ibex_obi_mem_responder
//
// Three responders (Latency 1, 3, 4) share one request stream. The driver
// predicts each response from a reference memory model and publishes it; each
// lane queues it at the grant edge and pops/compares when its rvalid is due.
// ---------------------------------------------------------------------------
module tb_ibex_obi_mem_responder;

  localparam logic [31:0] Base  = 32'h0010_0000;
  localparam int          NLane = 3;

  typedef struct {
    int          gc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [6:0]  wdata_intg_i;
  logic        gnt_stall_i;

  logic        gnt_w        [NLane];
  logic        rvalid_w     [NLane];
  logic        err_w        [NLane];
  logic        intg_err_w   [NLane];
  logic [31:0] rdata_w      [NLane];
  logic [6:0]  rdata_intg_w [NLane];
  logic [31:0] rd_cnt_w     [NLane];
  logic [31:0] wr_cnt_w     [NLane];
  logic [31:0] err_cnt_w    [NLane];

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  exp_t        exp_now;
  logic        push_now  = 1'b0;
  logic        final_chk = 1'b0;
  logic [31:0] model_mem [int];
  int unsigned m_rd, m_wr, m_err;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference integrity encoder, bit-serial over the check-bit masks.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  p;
    m = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
          32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
    for (int i = 0; i < 7; i++) begin
      p[i] = 1'b0;
      for (int j = 0; j < 32; j++) begin
        if (m[i][j]) p[i] = p[i] ^ d[j];
      end
    end
    return p ^ 7'b010_1010;
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < NLane; k++) begin : g_lane
    localparam int unsigned Lat = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    exp_t q[$];

    ibex_obi_mem_responder #(
      .MemWords (4096),
      .AddrBase (Base),
      .Latency  (Lat)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .gnt_o        (gnt_w[k]),
      .we_i         (we_i),
      .be_i         (be_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .wdata_intg_i (wdata_intg_i),
      .gnt_stall_i  (gnt_stall_i),
      .rvalid_o     (rvalid_w[k]),
      .rdata_o      (rdata_w[k]),
      .rdata_intg_o (rdata_intg_w[k]),
      .err_o        (err_w[k]),
      .intg_err_o   (intg_err_w[k]),
      .rd_cnt_o     (rd_cnt_w[k]),
      .wr_cnt_o     (wr_cnt_w[k]),
      .err_cnt_o    (err_cnt_w[k])
    );

    // Scoreboard push at the grant edge; reset drops everything in flight.
    always @(posedge clk) begin
      if (!rst_ni) q.delete();
      else if (push_now) q.push_back(exp_now);
    end

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
      exp_t e;
      logic due;
      due = (q.size() > 0) && (q[0].gc + int'(Lat) == cyc);
      chk_eq($sformatf("lat%0d rvalid cyc%0d", Lat, cyc), rvalid_w[k], due);
      if (due) begin
        e = q.pop_front();
        chk_eq($sformatf("lat%0d err cyc%0d", Lat, cyc), err_w[k], e.err);
        chk_eq($sformatf("lat%0d rdata cyc%0d", Lat, cyc), rdata_w[k], e.rdata);
        chk_eq($sformatf("lat%0d rdata_intg cyc%0d", Lat, cyc), rdata_intg_w[k], enc(e.rdata));
      end
      if (final_chk) chk_eq($sformatf("lat%0d drain", Lat), q.size(), 64'd0);
    end
  end

  task automatic chk_cnt(input string tag);
    for (int k = 0; k < NLane; k++) begin
      chk_eq($sformatf("%s rd_cnt[%0d]", tag, k), rd_cnt_w[k], m_rd);
      chk_eq($sformatf("%s wr_cnt[%0d]", tag, k), wr_cnt_w[k], m_wr);
      chk_eq($sformatf("%s err_cnt[%0d]", tag, k), err_cnt_w[k], m_err);
    end
  endtask

  // One request cycle, starting and ending on a falling edge.
  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [6:0] intg, input logic stall);
    logic        aerr, ierr, g;
    logic [31:0] rd, tmp;
    int          idx;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr;
    wdata_i = wdata; wdata_intg_i = intg; gnt_stall_i = stall;
    #1;
    g    = !stall && rst_ni;
    aerr = (addr < Base) || (addr >= Base + 32'h0000_4000) || (addr[1:0] != 2'b00);
    ierr = we && !aerr && (intg != enc(wdata));
    for (int k = 0; k < NLane; k++) begin
      chk_eq($sformatf("gnt[%0d] cyc%0d", k, cyc), gnt_w[k], g);
      chk_eq($sformatf("intg_err[%0d] cyc%0d", k, cyc), intg_err_w[k], g && ierr);
    end
    if (g) begin
      idx = int'((addr - Base) >> 2);
      rd  = 32'h0000_0000;
      if (!we && !aerr) rd = model_mem[idx];
      exp_now  = '{gc: cyc, err: aerr || ierr, rdata: rd};
      push_now = 1'b1;
      if (aerr || ierr) begin
        m_err++;
      end else if (we) begin
        m_wr++;
        tmp = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) begin
          if (be[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
        end
        model_mem[idx] = tmp;
      end else begin
        m_rd++;
      end
    end
    @(negedge clk);
    push_now = 1'b0; req_i = 1'b0; gnt_stall_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, be, addr, d, enc(d), 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr);
    drive(1'b0, 4'hF, addr, 32'h0, 7'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned op;
    logic [31:0] a, d;
    logic        st;

    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = Base;
    wdata_i = 32'h0; wdata_intg_i = 7'h00; gnt_stall_i = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;

    // Reset state, with a request held high during reset.
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NLane; k++) begin
      chk_eq($sformatf("rst gnt[%0d]", k), gnt_w[k], 1'b0);
      chk_eq($sformatf("rst rdata[%0d]", k), rdata_w[k], 32'h0);
      chk_eq($sformatf("rst err[%0d]", k), err_w[k], 1'b0);
      chk_eq($sformatf("rst rdata_intg[%0d]", k), rdata_intg_w[k], enc(32'h0));
    end
    chk_cnt("rst");
    req_i = 1'b0; rst_ni = 1'b1;
    @(negedge clk);

    // Write then read back-to-back.
    wr(Base + 32'h10, 32'hDEAD_BEEF, 4'hF);
    rd(Base + 32'h10);
    idle(3);
    for (int k = 0; k < NLane; k++) begin
      chk_eq($sformatf("wr_rd wr_cnt[%0d]", k), wr_cnt_w[k], 32'd1);
      chk_eq($sformatf("wr_rd rd_cnt[%0d]", k), rd_cnt_w[k], 32'd1);
    end

    // Partial write: model predicts 32'h11BB_33DD.
    wr(Base + 32'h30, 32'h1122_3344, 4'hF);
    wr(Base + 32'h30, 32'hAABB_CCDD, 4'b0101);
    rd(Base + 32'h30);
    idle(2);

    // Address errors, then confirm the array was untouched.
    wr(Base, 32'h0BAD_F00D, 4'hF);
    rd(32'h0000_0000);
    rd(Base + 32'h2);
    idle(1);
    for (int k = 0; k < NLane; k++) begin
      chk_eq($sformatf("addr_err err_cnt[%0d]", k), err_cnt_w[k], 32'd2);
    end
    rd(Base);

    // Array edges: last word, first byte past the end, word below the base.
    wr(Base + 32'h3FFC, 32'hCAFE_0001, 4'hF);
    rd(Base + 32'h3FFC);
    wr(Base + 32'h4000, 32'h1234_5678, 4'hF);
    rd(Base - 32'h4);
    idle(2);
    chk_cnt("range");

    // Bad write integrity must not modify the word.
    wr(Base + 32'h20, 32'h55AA_55AA, 4'hF);
    drive(1'b1, 4'hF, Base + 32'h20, 32'h1234_5678, enc(32'h1234_5678) ^ 7'h01, 1'b0);
    rd(Base + 32'h20);

    // Byte-enable zero write is a counted no-op.
    wr(Base + 32'h20, 32'hFFFF_FFFF, 4'h0);
    rd(Base + 32'h20);
    idle(5);
    chk_cnt("intg");

    // Four back-to-back reads, then a stalled request.
    rd(Base + 32'h10);
    rd(Base + 32'h20);
    rd(Base + 32'h30);
    rd(Base);
    drive(1'b0, 4'hF, Base + 32'h10, 32'h0, 7'h00, 1'b1);
    idle(6);
    chk_cnt("pipe");

    // Random traffic over a few pre-initialised words.
    for (int i = 0; i < 4; i++) wr(Base + 32'h40 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      a  = Base + 32'h40 + (32'($urandom_range(0, 3)) << 2);
      d  = $urandom;
      st = ($urandom_range(0, 4) == 0);
      case (op)
        0, 1, 2, 3: drive(1'b0, 4'hF, a, 32'h0, 7'h00, st);
        4, 5:       drive(1'b1, 4'($urandom_range(0, 15)), a, d, enc(d), st);
        6:          drive(1'b1, 4'hF, a, d, enc(d) ^ 7'h04, st);
        7:          drive(1'b0, 4'hF, a + 32'h1, 32'h0, 7'h00, st);
        8:          drive(1'b1, 4'hF, Base + 32'h4000 + a[7:0], d, enc(d), st);
        default:    idle(1);
      endcase
    end
    idle(6);
    chk_cnt("rand");

    // Reset two cycles after a grant drops the response and clears counters.
    rd(Base + 32'h10);
    idle(1);
    rst_ni = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt("midrst");
    rst_ni = 1'b1;
    idle(8);

    // Every queued response must have been consumed.
    @(posedge clk);
    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_obi_mem_responder.md
# ibex_obi_mem_responder

Memory-side responder for the Ibex instruction/data bus (req/gnt/rvalid protocol with 7-bit integrity). It accepts requests from the core's initiator port and performs word reads and byte-enabled writes on an internal word array. It returns in-order responses at a fixed latency, with integrity bits generated on read data and checked on write data. It is instantiated once per bus port in simulation and FPGA tops, next to the tracing top.

## Interface
- `MemWords`, 4096: number of 32-bit words; address range is `[AddrBase, AddrBase + 4*MemWords)`.
- `AddrBase`, 32'h0010_0000: byte base address.
- `Latency`, 1: cycles from grant to rvalid; legal range 1..8.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_i` in 1: request valid.
- `gnt_o` out 1: request accepted this cycle.
- `we_i` in 1: write when 1.
- `be_i` in 4: byte enables.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: write data.
- `wdata_intg_i` in 7: integrity bits for `wdata_i`.
- `gnt_stall_i` in 1: bench/fabric back-pressure; forces `gnt_o` = 0.
- `rvalid_o` out 1: response valid, single-cycle pulse per granted request.
- `rdata_o` out 32: read data (0 for writes and errors).
- `rdata_intg_o` out 7: integrity bits of `rdata_o`.
- `err_o` out 1: response is an error; qualified by `rvalid_o`.
- `intg_err_o` out 1: one-cycle pulse at grant of a write with bad integrity.
- `rd_cnt_o`, `wr_cnt_o`, `err_cnt_o` out 32 each: saturating event counters.

## Operation
- Grant is combinational: `gnt_o = req_i & ~gnt_stall_i & rst_ni`. A handshake occurs when `req_i & gnt_o`.
- The memory access happens in the grant cycle:
  - Reads sample the array in that cycle.
  - Writes update bytes where `be_i` = 1 at the clock edge ending that cycle.
  - A read granted the cycle after a write to the same word returns the new data.
- Error checks, in priority order:
  - Out-of-range address or `addr_i[1:0]` != 0: error, no write.
  - Write whose `wdata_intg_i` != encode(`wdata_i`): error, no write, `intg_err_o` = 1.
- Writes with `be_i` = 0 are legal no-ops and count in `wr_cnt_o`.
- Response pipeline:
  - A `Latency`-deep shift register of {valid, err, rdata}.
  - The pipeline never stalls, because the protocol has no response back-pressure.
  - Up to `Latency` requests can be outstanding; responses stay in order.
- `rdata_intg_o` is always encode(`rdata_o`), including for error and write responses. The encoding is the inverted SECDED 39/32 code.
- Counters:
  - `rd_cnt_o` and `wr_cnt_o` increment on accepted non-error requests.
  - `err_cnt_o` increments on every error response.
  - All counters saturate at 32'hFFFF_FFFF.
- There is no FSM beyond the pipeline; the block is stateless between requests except for the array and the counters.

## Timing
- Reset values: `gnt_o` 0; pipeline valids 0; `rvalid_o` 0; `rdata_o` 0; `err_o` 0; `intg_err_o` 0; counters 0. Array contents are not reset.
- Reset asserted mid-operation: in-flight responses are dropped and `rvalid_o` is 0 from the first cycle after the reset edge. Counters clear and array writes are suppressed while `rst_ni` = 0.
- A grant in cycle N produces `rvalid_o` in cycle N+`Latency`.
- Back-to-back grants give back-to-back rvalids.
- `gnt_stall_i` has no effect on requests already in flight.
- Counter updates are visible the cycle after the grant.
- A simultaneous grant and response retiring in the same cycle is legal at any `Latency`.

## Structure
- Shared package `ibex_obi_mem_pkg`:
  - `obi_rsp_t` struct {err, rdata, rdata_intg}.
  - Constant `MaxLatency` = 8.
  - Function `intg_enc(logic [31:0])`, wrapping `prim_secded_inv_39_32_enc`.
- One sub-module, `ibex_obi_rsp_pipe`: parameterised-depth valid/payload shift register carrying `obi_rsp_t`.
- The word array is inferred in the top module; there is no separate RAM primitive.

## Test plan
- Write then read:
  - Stimulus: write 32'hDEAD_BEEF, `be`=4'hF, to 32'h0010_0010; then read it, `Latency`=1.
  - Required: `rvalid_o` the cycle after each grant; read `rdata_o` = 32'hDEAD_BEEF, `rdata_intg_o` = encode(DEAD_BEEF), `err_o` = 0; `wr_cnt_o` = 1, `rd_cnt_o` = 1.
- Partial write:
  - Stimulus: word holds 32'h1122_3344; write 32'hAABB_CCDD with `be`=4'b0101; read back.
  - Required: read returns 32'h11BB_33DD.
- Error cases:
  - Stimulus: read 32'h0000_0000, then read 32'h0010_0002.
  - Required: both respond `err_o` = 1 and `rdata_o` = 0; `err_cnt_o` = 2; array unchanged.
- Bad integrity:
  - Stimulus: write to 32'h0010_0020 with `wdata_intg_i` bit 0 flipped.
  - Required: `intg_err_o` pulses in the grant cycle, the response has `err_o` = 1, and a later read returns the old word.
- Pipelining at `Latency`=3:
  - Stimulus: 4 back-to-back reads granted in cycles 10-13; `gnt_stall_i` high in cycle 14.
  - Required: rvalid in cycles 13-16, in order, correct data; no grant in cycle 14.
- Reset mid-flight:
  - Stimulus: `Latency`=4; assert `rst_ni`=0 two cycles after a grant.
  - Required: no rvalid for that request; all counters read 0 after reset.
